// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: FSM states, requester
// indices, default widths and the saturation ceiling of the returned result.
package divider_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } arbState_e;

   localparam logic REQ_SPEED = 1'b0;
   localparam logic REQ_AVG   = 1'b1;

   localparam int DEFAULT_DIV_WIDTH = 16;
   localparam int DEFAULT_OUT_WIDTH = 12;
   localparam int SAT_MAX           = (1 << DEFAULT_OUT_WIDTH) - 1;

endpackage

// File: rtl/divider_arbiter_seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock, MSB first.
// The dividend is loaded into the quotient register and shifted out as quotient bits come in.
module seq_divider
   import divider_arbiter_pkg::*;
#(
   parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic [DIV_WIDTH-1:0] dividend_i,
   input  logic [DIV_WIDTH-1:0] divisor_i,
   output logic                 done_o,
   output logic [DIV_WIDTH-1:0] quotient_o,
   output logic                 divzero_o
);

   localparam int CntW = $clog2(DIV_WIDTH);

   logic [DIV_WIDTH:0]   rem_q, rem_d, shifted;
   logic [DIV_WIDTH-1:0] quot_q, quot_d, divisor_q;
   logic [CntW-1:0]      count_q;
   logic                 run_q;
   logic                 qBit;

   // The extra remainder bit keeps the shifted value from overflowing before the compare.
   always_comb begin
      shifted = (rem_q << 1) | {{DIV_WIDTH{1'b0}}, quot_q[DIV_WIDTH-1]};
      qBit    = (shifted >= {1'b0, divisor_q});
      rem_d   = qBit ? (shifted - {1'b0, divisor_q}) : shifted;
      quot_d  = {quot_q[DIV_WIDTH-2:0], qBit};
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rem_q     <= '0;
         quot_q    <= '0;
         divisor_q <= '0;
         count_q   <= '0;
         run_q     <= 1'b0;
      end else if (start_i) begin
         rem_q     <= '0;
         quot_q    <= dividend_i;
         divisor_q <= divisor_i;
         count_q   <= CntW'(DIV_WIDTH - 1);
         run_q     <= (divisor_i != '0);
      end else if (run_q) begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
         if (count_q == '0) begin
            run_q <= 1'b0;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign done_o     = run_q && (count_q == '0);
   assign quotient_o = quot_q;
   assign divzero_o  = (divisor_q == '0);

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one iterative divider between the speed and average-speed
// calculators; returns a saturated quotient with a one-cycle ack per requester.
module divider_arbiter
   import divider_arbiter_pkg::*;
#(
   parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH,
   parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_speed,
   input  logic [DIV_WIDTH-1:0] dividend_speed,
   input  logic [DIV_WIDTH-1:0] divisor_speed,
   output logic                 ack_speed,
   output logic [OUT_WIDTH-1:0] result_speed,
   input  logic                 req_avg,
   input  logic [DIV_WIDTH-1:0] dividend_avg,
   input  logic [DIV_WIDTH-1:0] divisor_avg,
   output logic                 ack_avg,
   output logic [OUT_WIDTH-1:0] result_avg,
   output logic                 busy
);

   localparam logic [DIV_WIDTH-1:0] SatLimit = DIV_WIDTH'((1 << OUT_WIDTH) - 1);

   arbState_e            state_q, state_d;
   logic                 ptr_q, owner_q, ackSpeed_q, ackAvg_q;
   logic [OUT_WIDTH-1:0] resultSpeed_q, resultAvg_q, satResult;
   logic                 reqSpeedLive, reqAvgLive, anyReq, grantAvg, startDiv;
   logic                 divDone, divZero;
   logic [DIV_WIDTH-1:0] selDividend, selDivisor, divQuotient;

   // A request is ignored while its own ack is still high, so a requester that
   // drops req one cycle late is not served twice.
   always_comb begin
      reqSpeedLive = req_speed && !ackSpeed_q;
      reqAvgLive   = req_avg && !ackAvg_q;
      anyReq       = reqSpeedLive || reqAvgLive;
      grantAvg     = (reqSpeedLive && reqAvgLive) ? (ptr_q == REQ_AVG) : reqAvgLive;
      selDividend  = grantAvg ? dividend_avg : dividend_speed;
      selDivisor   = grantAvg ? divisor_avg : divisor_speed;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (anyReq) state_d = (selDivisor == '0) ? DONE : CALC;
         CALC: if (divDone) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      startDiv = (state_q == IDLE) && anyReq;
   end

   seq_divider #(
      .DIV_WIDTH(DIV_WIDTH)
   ) uDivider (
      .clock     (clock),
      .reset     (reset),
      .start_i   (startDiv),
      .dividend_i(selDividend),
      .divisor_i (selDivisor),
      .done_o    (divDone),
      .quotient_o(divQuotient),
      .divzero_o (divZero)
   );

   assign satResult = (divZero || (divQuotient > SatLimit)) ? {OUT_WIDTH{1'b1}}
                                                            : divQuotient[OUT_WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr_q         <= REQ_SPEED;
         owner_q       <= REQ_SPEED;
         ackSpeed_q    <= 1'b0;
         ackAvg_q      <= 1'b0;
         resultSpeed_q <= '0;
         resultAvg_q   <= '0;
      end else begin
         ackSpeed_q <= 1'b0;
         ackAvg_q   <= 1'b0;
         if (startDiv) begin
            owner_q <= grantAvg;
            ptr_q   <= !grantAvg;
         end
         if (state_q == DONE) begin
            if (owner_q == REQ_AVG) begin
               resultAvg_q <= satResult;
               ackAvg_q    <= 1'b1;
            end else begin
               resultSpeed_q <= satResult;
               ackSpeed_q    <= 1'b1;
            end
         end
      end
   end

   assign ack_speed    = ackSpeed_q;
   assign ack_avg      = ackAvg_q;
   assign result_speed = resultSpeed_q;
   assign result_avg   = resultAvg_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter: directed latency/saturation/reset/fairness cases
// followed by two randomized requesters checked against an arithmetic reference.
module tb_divider_arbiter;
   import divider_arbiter_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_speed, req_avg;
   logic [15:0] dividend_speed, divisor_speed, dividend_avg, divisor_avg;
   logic        ack_speed, ack_avg, busy;
   logic [11:0] result_speed, result_avg;

   int assertCount = 0;
   int failCount   = 0;
   int pendSpeed, pendAvg, lastSpeed, lastAvg;
   bit pendSpeedValid, pendAvgValid;
   int ackOrder[$];

   always #5 clock = ~clock;

   divider_arbiter #(
      .DIV_WIDTH(16),
      .OUT_WIDTH(12)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req_speed     (req_speed),
      .dividend_speed(dividend_speed),
      .divisor_speed (divisor_speed),
      .ack_speed     (ack_speed),
      .result_speed  (result_speed),
      .req_avg       (req_avg),
      .dividend_avg  (dividend_avg),
      .divisor_avg   (divisor_avg),
      .ack_avg       (ack_avg),
      .result_avg    (result_avg),
      .busy          (busy)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Expected result straight from the arithmetic: saturated unsigned quotient.
   function automatic int refDiv(input logic [15:0] a, input logic [15:0] b);
      int q;
      if (b == 16'd0) return SAT_MAX;
      q = int'(a) / int'(b);
      return (q > SAT_MAX) ? SAT_MAX : q;
   endfunction

   task automatic applyStimulus(input logic who, input bit req,
                                input logic [15:0] dvd, input logic [15:0] dvs);
      if (who == REQ_AVG) begin
         req_avg = req; dividend_avg = dvd; divisor_avg = dvs;
         if (req) begin pendAvg = refDiv(dvd, dvs); pendAvgValid = 1'b1; end
      end else begin
         req_speed = req; dividend_speed = dvd; divisor_speed = dvs;
         if (req) begin pendSpeed = refDiv(dvd, dvs); pendSpeedValid = 1'b1; end
      end
   endtask

   task automatic doReset();
      reset = 1'b0; req_speed = 1'b0; req_avg = 1'b0;
      @(posedge clock); #1;
      pendSpeedValid = 1'b0; pendAvgValid = 1'b0; lastSpeed = 0; lastAvg = 0;
      @(negedge clock); @(negedge clock);
      reset = 1'b1;
   endtask

   // lat = number of edges after the grant edge at which the ack was first seen.
   task automatic waitAck(input logic who, input int maxCycles, output int lat, output int busyCnt);
      lat = -1; busyCnt = 0;
      for (int j = 0; j < maxCycles; j++) begin
         @(negedge clock);
         if ((who == REQ_AVG) ? ack_avg : ack_speed) begin lat = j; break; end
         if (busy) busyCnt++;
      end
   endtask

   task automatic pickOperands(output logic [15:0] dvd, output logic [15:0] dvs);
      int unsigned sel;
      sel = $urandom_range(9, 0);
      dvd = 16'($urandom);
      case (sel)
         0: dvs = 16'd0;
         1: dvs = 16'd1;
         2: begin dvd = 16'($urandom_range(500, 0)); dvs = 16'($urandom_range(40, 1)); end
         3: dvs = 16'($urandom);
         default: dvs = 16'($urandom_range(300, 1));
      endcase
   endtask

   // holdMode: 0 drop req right at ack, 1 hold one extra cycle, 2 random choice.
   task automatic runAgent(input logic who, input int nJobs, input int maxGap, input int holdMode);
      int lat, bc, gap;
      logic [15:0] dvd, dvs;
      bit hold;
      for (int n = 0; n < nJobs; n++) begin
         gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
         repeat (gap) @(negedge clock);
         pickOperands(dvd, dvs);
         applyStimulus(who, 1'b1, dvd, dvs);
         waitAck(who, 100, lat, bc);
         checkOutput((who == REQ_AVG) ? "agent_avg_ack_seen" : "agent_speed_ack_seen",
                     int'(lat >= 0), 1);
         hold = (holdMode == 1) || ((holdMode == 2) && ($urandom_range(1, 0) == 1));
         if (hold) @(negedge clock);
         applyStimulus(who, 1'b0, 16'($urandom), 16'($urandom));
         @(negedge clock);
      end
   endtask

   // Every ack must answer an outstanding request, carry the reference result,
   // and leave the other requester's result untouched.
   always @(negedge clock) begin
      if (ack_speed || ack_avg)
         checkOutput("single_ack", int'(ack_speed) + int'(ack_avg), 1);
      if (ack_speed) begin
         checkOutput("ack_speed_requested", int'(pendSpeedValid), 1);
         checkOutput("result_speed", int'(result_speed), pendSpeed);
         checkOutput("result_avg_held", int'(result_avg), lastAvg);
         lastSpeed = pendSpeed; pendSpeedValid = 1'b0; ackOrder.push_back(0);
      end
      if (ack_avg) begin
         checkOutput("ack_avg_requested", int'(pendAvgValid), 1);
         checkOutput("result_avg", int'(result_avg), pendAvg);
         checkOutput("result_speed_held", int'(result_speed), lastSpeed);
         lastAvg = pendAvg; pendAvgValid = 1'b0; ackOrder.push_back(1);
      end
   end

   initial begin
      int lat, bc, acks, busyCnt;
      int t4Dvd[3] = '{65535, 4095, 4096};
      int t4Dvs[3] = '{1, 1, 2};
      int t4Res[3] = '{4095, 4095, 2048};

      reset = 1'b0; req_speed = 1'b0; req_avg = 1'b0;
      dividend_speed = '0; divisor_speed = '0; dividend_avg = '0; divisor_avg = '0;
      pendSpeedValid = 1'b0; pendAvgValid = 1'b0; lastSpeed = 0; lastAvg = 0;
      pendSpeed = 0; pendAvg = 0;
      @(negedge clock);
      doReset();
      checkOutput("reset_ack_speed", int'(ack_speed), 0);
      checkOutput("reset_ack_avg", int'(ack_avg), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_result_speed", int'(result_speed), 0);
      checkOutput("reset_result_avg", int'(result_avg), 0);

      $display("[TB] single speed division 1000/7");
      applyStimulus(REQ_SPEED, 1'b1, 16'd1000, 16'd7);
      waitAck(REQ_SPEED, 40, lat, bc);
      checkOutput("t1_latency", lat, 17);
      checkOutput("t1_busy_cycles", bc, 17);
      checkOutput("t1_result_speed", int'(result_speed), 142);
      checkOutput("t1_result_avg", int'(result_avg), 0);
      applyStimulus(REQ_SPEED, 1'b0, 16'd0, 16'd0);
      @(negedge clock);

      $display("[TB] avg divide by zero");
      applyStimulus(REQ_AVG, 1'b1, 16'd1234, 16'd0);
      waitAck(REQ_AVG, 40, lat, bc);
      checkOutput("t3_latency", lat, 1);
      checkOutput("t3_busy_cycles", bc, 1);
      checkOutput("t3_result_avg", int'(result_avg), 4095);
      applyStimulus(REQ_AVG, 1'b0, 16'd0, 16'd0);
      @(negedge clock);

      $display("[TB] saturation boundary");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(REQ_SPEED, 1'b1, 16'(t4Dvd[i]), 16'(t4Dvs[i]));
         if (i == 2) begin
            @(negedge clock);
            dividend_speed = 16'd9; divisor_speed = 16'd0;
            waitAck(REQ_SPEED, 40, lat, bc);
            if (lat >= 0) lat++;
         end else begin
            waitAck(REQ_SPEED, 40, lat, bc);
         end
         checkOutput($sformatf("t4_latency%0d", i), lat, 17);
         checkOutput($sformatf("t4_result%0d", i), int'(result_speed), t4Res[i]);
         applyStimulus(REQ_SPEED, 1'b0, 16'd0, 16'd0);
         @(negedge clock);
      end

      $display("[TB] reset in the middle of a division");
      applyStimulus(REQ_SPEED, 1'b1, 16'd1000, 16'd7);
      repeat (8) @(negedge clock);
      doReset();
      checkOutput("t5_ack_speed", int'(ack_speed), 0);
      checkOutput("t5_busy", int'(busy), 0);
      checkOutput("t5_result_speed", int'(result_speed), 0);
      checkOutput("t5_result_avg", int'(result_avg), 0);
      acks = 0; busyCnt = 0;
      repeat (25) begin
         @(negedge clock);
         if (ack_speed || ack_avg) acks++;
         if (busy) busyCnt++;
      end
      checkOutput("t5_no_ack", acks, 0);
      checkOutput("t5_idle", busyCnt, 0);
      applyStimulus(REQ_SPEED, 1'b1, 16'd1000, 16'd7);
      waitAck(REQ_SPEED, 40, lat, bc);
      checkOutput("t5_latency", lat, 17);
      checkOutput("t5_result_speed", int'(result_speed), 142);
      applyStimulus(REQ_SPEED, 1'b0, 16'd0, 16'd0);
      @(negedge clock);

      $display("[TB] simultaneous requests after reset");
      doReset();
      applyStimulus(REQ_SPEED, 1'b1, 16'd3600, 16'd9);
      applyStimulus(REQ_AVG, 1'b1, 16'd5000, 16'd100);
      waitAck(REQ_SPEED, 40, lat, bc);
      checkOutput("t2_speed_latency", lat, 17);
      checkOutput("t2_result_speed", int'(result_speed), 400);
      applyStimulus(REQ_SPEED, 1'b0, 16'd0, 16'd0);
      waitAck(REQ_AVG, 40, lat, bc);
      checkOutput("t2_avg_latency", lat, 17);
      checkOutput("t2_result_avg", int'(result_avg), 50);
      applyStimulus(REQ_AVG, 1'b0, 16'd0, 16'd0);
      @(negedge clock);

      $display("[TB] fairness under continuous contention");
      doReset();
      ackOrder.delete();
      fork
         runAgent(REQ_SPEED, 3, 0, 1);
         runAgent(REQ_AVG, 3, 0, 1);
      join
      checkOutput("t6_ack_count", ackOrder.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < ackOrder.size()) checkOutput($sformatf("t6_order%0d", i), ackOrder[i], i % 2);
      end
      acks = 0; busyCnt = 0;
      repeat (25) begin
         @(negedge clock);
         if (ack_speed || ack_avg) acks++;
         if (busy) busyCnt++;
      end
      checkOutput("t6_no_regrant_ack", acks, 0);
      checkOutput("t6_no_regrant_busy", busyCnt, 0);

      $display("[TB] randomized requesters");
      fork
         runAgent(REQ_SPEED, 10, 5, 2);
         runAgent(REQ_AVG, 10, 5, 2);
      join
      repeat (5) @(negedge clock);
      checkOutput("final_no_pending_speed", int'(pendSpeedValid), 0);
      checkOutput("final_no_pending_avg", int'(pendAvgValid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
